// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder line-scan sequencer.
// Holds the FSM encoding and the decoder geometry.
// No logic; imported by the scanner top and its helper.
package decoder_scan_ctrl_pkg;

  localparam int NUM_LINES = 8;
  localparam int SEL_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_scan_next_sel.sv
// Finds the next enabled decoder line: lowest set index above cur, or lowest overall.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is valid whenever inputs are stable.
module scan_next_sel
  import decoder_scan_ctrl_pkg::*;
(
  input  logic [NUM_LINES-1:0] mask,
  input  logic [SEL_W-1:0]     cur,
  input  logic                 from_start,
  output logic [SEL_W-1:0]     nxt,
  output logic                 found
);

  // Scan from the top down so the lowest qualifying index is the last one written.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (SEL_W'(i) > cur))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scans the 3-to-8 decoder lines in ascending order with en-low blanking between lines.
// Latency: en rises one clock after start is sampled; done pulses one clock after the last line.
// Backpressure: none; start is ignored while a frame runs, abort stops at once.
module decoder_scan_ctrl
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 cont,
  input  logic [NUM_LINES-1:0] mask,
  output logic [SEL_W-1:0]     sel,
  output logic                 en,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LINES-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 en_q, busy_q, done_q;
  logic                 done_d;

  logic [SEL_W-1:0]     adv_nxt, start_nxt;
  logic                 adv_found, start_found;
  logic                 dwell_last, blank_last;

  // Next line within the frame, taken from the latched mask.
  scan_next_sel u_adv (
    .mask       (mask_q),
    .cur        (sel_q),
    .from_start (1'b0),
    .nxt        (adv_nxt),
    .found      (adv_found)
  );

  // First line of a new frame, taken from the live mask input (start or wrap).
  scan_next_sel u_first (
    .mask       (mask),
    .cur        (sel_q),
    .from_start (1'b1),
    .nxt        (start_nxt),
    .found      (start_found)
  );

  assign dwell_last = (cnt_q == CNT_W'(DWELL - 1));
  assign blank_last = (cnt_q == CNT_W'(BLANK - 1));

  // Next-state, counter, mask latch and select update; abort overrides the normal flow.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_found) begin
            mask_d  = mask;
            sel_d   = start_nxt;
            cnt_d   = '0;
            state_d = ST_ACTIVE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (dwell_last) begin
          cnt_d = '0;
          if (adv_found) begin
            sel_d   = adv_nxt;
            state_d = ST_GAP;
          end else if (cont) begin
            // Wrap: the mask is refreshed from the input at every frame boundary.
            mask_d = mask;
            if (start_found) begin
              sel_d   = start_nxt;
              state_d = ST_GAP;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (blank_last) begin
          cnt_d   = '0;
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      mask_d  = mask_q;
      sel_d   = sel_q;
      done_d  = 1'b0;
    end
  end

  // State, counter and registered outputs; en/busy are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      en_q    <= (state_d == ST_ACTIVE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
